// File: rtl/regs_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package regs_arb_pkg;
  typedef enum logic {CLEAR, RUN} arb_state_t;
  typedef enum logic {REQ_CPU, REQ_IO} req_id_t;
  localparam logic [31:0] ZERO_REG = '0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the requester that did not win last time wins.
module rr_arb2
  import regs_arb_pkg::*;
(
  input  logic       req_cpu_i,
  input  logic       req_io_i,
  input  req_id_t    last_i,
  output logic [1:0] gnt_o,
  output req_id_t    win_o
);
  always_comb begin
    gnt_o = 2'b00;
    win_o = REQ_CPU;
    if (req_cpu_i && req_io_i) begin
      win_o = (last_i == REQ_CPU) ? REQ_IO : REQ_CPU;
    end else if (req_io_i) begin
      win_o = REQ_IO;
    end
    if (req_cpu_i || req_io_i) begin
      if (win_o == REQ_IO) gnt_o = 2'b10;
      else                 gnt_o = 2'b01;
    end
  end
endmodule

// File: rtl/regs_wr_arbiter.sv
// Write-port controller for the register file: zero sweep after reset, then
// round-robin sharing between the ALU writeback and the I/O loader.
module regs_wr_arbiter
  import regs_arb_pkg::*;
#(
  parameter int n     = 8,
  parameter int AW    = 5,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_rdno,
  input  logic [n-1:0]  cpu_wdata,
  output logic          cpu_gnt,
  input  logic          io_req,
  input  logic [AW-1:0] io_rdno,
  input  logic [n-1:0]  io_wdata,
  output logic          io_gnt,
  output logic          busy,
  output logic          w,
  output logic [AW-1:0] Rdno,
  output logic [n-1:0]  Wdata
);
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  arb_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  req_id_t       last_q, last_d;
  logic          w_q, w_d;
  logic [AW-1:0] rdno_q, rdno_d;
  logic [n-1:0]  wdata_q, wdata_d;

  logic [1:0]    arb_gnt;
  req_id_t       arb_win;
  logic          gnt_en;

  rr_arb2 u_rr (
    .req_cpu_i (cpu_req),
    .req_io_i  (io_req),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .win_o     (arb_win)
  );

  // Grants are masked during reset so no requester sees a write that is about to be dropped.
  assign gnt_en  = !reset && (state_q == RUN);
  assign cpu_gnt = gnt_en && arb_gnt[0];
  assign io_gnt  = gnt_en && arb_gnt[1];
  assign busy    = reset || (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    w_d     = 1'b0;
    rdno_d  = rdno_q;
    wdata_d = wdata_q;
    case (state_q)
      CLEAR: begin
        w_d     = 1'b1;
        rdno_d  = cnt_q;
        wdata_d = '0;
        if (cnt_q == LAST_REG) state_d = RUN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RUN: begin
        if (cpu_gnt || io_gnt) begin
          last_d  = arb_win;
          rdno_d  = (arb_win == REQ_IO) ? io_rdno  : cpu_rdno;
          wdata_d = (arb_win == REQ_IO) ? io_wdata : cpu_wdata;
          // %0 is hardwired zero: grant consumed, write suppressed.
          w_d     = (rdno_d != AW'(ZERO_REG));
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      last_q  <= REQ_IO;
      w_q     <= 1'b0;
      rdno_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      w_q     <= w_d;
      rdno_q  <= rdno_d;
      wdata_q <= wdata_d;
    end
  end

  assign w     = w_q;
  assign Rdno  = rdno_q;
  assign Wdata = wdata_q;
endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Randomized bench: cycle-count reference model of sweep, round-robin grants and register contents.
module tb_regs_wr_arbiter;
  localparam int N  = 8;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, io_req;
  logic [AW-1:0] cpu_rdno, io_rdno;
  logic [N-1:0]  cpu_wdata, io_wdata;
  logic          cpu_gnt, io_gnt, busy, w;
  logic [AW-1:0] Rdno;
  logic [N-1:0]  Wdata;

  regs_wr_arbiter #(.n(N), .AW(AW), .NREGS(NR)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rdno(cpu_rdno), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .io_req(io_req), .io_rdno(io_rdno), .io_wdata(io_wdata), .io_gnt(io_gnt),
    .busy(busy), .w(w), .Rdno(Rdno), .Wdata(Wdata)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: cycles since reset fell, last winner (1 = io), predicted port.
  int            mcyc;
  bit            mlast;
  bit            ev;
  bit            ew;
  logic [AW-1:0] erd;
  logic [N-1:0]  ewd;
  bit            gc, gi;
  logic [N-1:0]  mmem [NR];
  logic [N-1:0]  dmem [NR];

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_rdno = '0; cpu_wdata = '0;
    io_req = 1'b0;  io_rdno = '0;  io_wdata = '0;
    mcyc = 0; mlast = 1'b1; ev = 1'b0; ew = 1'b0; erd = '0; ewd = '0;
    gc = 1'b0; gi = 1'b0;
    for (int k = 0; k < NR; k++) begin
      mmem[k] = 8'hAA;
      dmem[k] = 8'hAA;
    end

    for (int i = 0; i < 800; i++) begin
      int pc;
      @(negedge clk);
      if (ev) begin
        chk("w", 32'(w), 32'(ew));
        if (ew) begin
          chk("Rdno", 32'(Rdno), 32'(erd));
          chk("Wdata", 32'(Wdata), 32'(ewd));
          mmem[erd] = ewd;
        end
      end
      if (w === 1'b1) dmem[Rdno] = Wdata;

      // Stimulus: granted requests retire, new ones arrive at random and hold until granted.
      reset = (i < 2) || (i == 12) || (i > 120 && $urandom_range(0, 99) == 0);
      if (gc) cpu_req = 1'b0;
      if (gi) io_req = 1'b0;
      pc = (i >= 300 && i < 340) ? 100 : 40;
      if (!cpu_req && $urandom_range(0, 99) < pc) begin
        cpu_req = 1'b1; cpu_rdno = AW'($urandom_range(0, 7)); cpu_wdata = N'($urandom);
      end
      if (!io_req && $urandom_range(0, 99) < pc) begin
        io_req = 1'b1; io_rdno = AW'($urandom_range(0, 7)); io_wdata = N'($urandom);
      end
      #1;

      chk("busy", 32'(busy), 32'(reset || mcyc < NR));
      gc = 1'b0; gi = 1'b0;
      if (!reset && mcyc >= NR) begin
        if (cpu_req && io_req) begin
          if (mlast) gc = 1'b1;
          else       gi = 1'b1;
        end else begin
          gc = cpu_req;
          gi = io_req;
        end
      end
      chk("cpu_gnt", 32'(cpu_gnt), 32'(gc));
      chk("io_gnt", 32'(io_gnt), 32'(gi));

      // Prediction for the port contents in the next cycle.
      if (reset) begin
        ew = 1'b0; erd = '0; ewd = '0; mlast = 1'b1;
      end else if (mcyc < NR) begin
        ew = 1'b1; erd = AW'(mcyc); ewd = '0;
      end else if (gc || gi) begin
        erd   = gc ? cpu_rdno : io_rdno;
        ewd   = gc ? cpu_wdata : io_wdata;
        ew    = (erd != 0);
        mlast = gi;
      end else begin
        ew = 1'b0;
      end
      if (reset)          mcyc = 0;
      else if (mcyc < NR) mcyc = mcyc + 1;
      ev = 1'b1;
    end

    @(negedge clk);
    chk("w_last", 32'(w), 32'(ew));
    if (ew) mmem[erd] = ewd;
    if (w === 1'b1) dmem[Rdno] = Wdata;
    for (int k = 0; k < NR; k++) chk($sformatf("mem[%0d]", k), 32'(dmem[k]), 32'(mmem[k]));
    chk("mem0_zero", 32'(dmem[0]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
